// File: rtl/disp_pkg.sv
// Shared definitions for the RGB channel display: glyph constants in
// active-low {g,f,e,d,c,b,a} order and the channel-select encoding.
package disp_pkg;

  // Channel select encoding, shared with the upstream selector.
  typedef enum logic [1:0] {
    CH_B    = 2'b00,
    CH_G    = 2'b01,
    CH_R    = 2'b10,
    CH_NONE = 2'b11
  } chan_sel_t;

  // Digit positions on the 4-digit display.
  localparam logic [1:0] DIG_LO     = 2'd0;  // low hex nibble
  localparam logic [1:0] DIG_HI     = 2'd1;  // high hex nibble
  localparam logic [1:0] DIG_GAP    = 2'd2;  // always blank
  localparam logic [1:0] DIG_LETTER = 2'd3;  // channel letter

  // Non-hex glyphs, active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_b     = 7'b0000011;
  localparam logic [6:0] SEG_G     = 7'b1000010;
  localparam logic [6:0] SEG_r     = 7'b0101111;

  // All anodes off.
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Letter shown on the leftmost digit for a given channel.
  function automatic logic [6:0] letter_glyph(input chan_sel_t sel);
    logic [6:0] g;
    case (sel)
      CH_B:    g = SEG_b;
      CH_G:    g = SEG_G;
      CH_R:    g = SEG_r;
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

  // One-hot-low anode pattern for a digit index.
  function automatic logic [3:0] anode_onehot_low(input logic [1:0] dig);
    logic [3:0] a;
    a      = 4'b1111;
    a[dig] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low 7-segment decoder, {g,f,e,d,c,b,a}.
module hex_to_7seg (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Standard hex glyph table.
  always_comb begin
    o_seg = 7'b1111111;
    case (i_nibble)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/rgb_channel_display.sv
// 4-digit common-anode display of the selected RGB channel: letter on
// digit 3, blank digit 2, hex value on digits 1..0. Inputs are captured
// once per scan frame so a frame is always internally consistent.
module rgb_channel_display
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLANK       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] channel_in,
  input  logic [1:0] sel,
  output logic [3:0] anodes,
  output logic [6:0] segments,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  // Scan state
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_digit;

  // Frame shadow of the inputs
  chan_sel_t     r_sel_s;
  logic [7:0]    r_val_s;

  // Registered outputs
  logic [3:0]    r_anodes;
  logic [6:0]    r_segments;

  // Combinational helpers
  logic          w_slot_end;
  logic          w_snapshot;
  logic [3:0]    w_nibble;
  logic [6:0]    w_hex_seg;
  logic [6:0]    w_glyph;
  logic [3:0]    w_anodes;

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_snapshot = w_slot_end && (r_digit == DIG_LETTER);

  // Slot counter and digit index: the index steps when the slot wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_digit <= 2'd0;
    end else if (w_slot_end) begin
      r_cnt   <= '0;
      r_digit <= r_digit + 2'd1;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Shadow capture on the last cycle of the last digit slot only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_s <= CH_NONE;
      r_val_s <= 8'h00;
    end else if (w_snapshot) begin
      r_sel_s <= chan_sel_t'(sel);
      r_val_s <= channel_in;
    end
  end

  // Nibble for the hex digits; digit 0 is the low nibble.
  assign w_nibble = (r_digit == DIG_LO) ? r_val_s[3:0] : r_val_s[7:4];

  hex_to_7seg u_hex (
    .i_nibble (w_nibble),
    .o_seg    (w_hex_seg)
  );

  // Glyph mux: "no channel" shows dashes on every digit.
  always_comb begin
    w_glyph = SEG_BLANK;
    if (r_sel_s == CH_NONE) begin
      w_glyph = SEG_DASH;
    end else begin
      case (r_digit)
        DIG_LO:     w_glyph = w_hex_seg;
        DIG_HI:     w_glyph = w_hex_seg;
        DIG_GAP:    w_glyph = SEG_BLANK;
        DIG_LETTER: w_glyph = letter_glyph(r_sel_s);
        default:    w_glyph = SEG_BLANK;
      endcase
    end
  end

  // Anodes stay off for the leading part of each slot so the previous
  // digit's segments never ghost onto the new digit.
  always_comb begin
    w_anodes = AN_OFF;
    if (r_cnt >= CNT_BLANK) begin
      w_anodes = anode_onehot_low(r_digit);
    end
  end

  // Output registers: one cycle behind the scan state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_anodes   <= AN_OFF;
      r_segments <= SEG_BLANK;
    end else begin
      r_anodes   <= w_anodes;
      r_segments <= w_glyph;
    end
  end

  assign anodes   = r_anodes;
  assign segments = r_segments;
  assign dp       = 1'b1;

endmodule

// File: tb/tb_rgb_channel_display.sv
// Directed bench for rgb_channel_display with a short scan slot so whole
// frames are checked cycle by cycle against hand-written glyphs.
module tb_rgb_channel_display;

  localparam int RD     = 8;
  localparam int BL     = 2;
  localparam int FRAME  = 4 * RD;

  // Hand-written active-low glyphs {g..a}
  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_DASH  = 7'b0111111;
  localparam logic [6:0] G_LB    = 7'b0000011;
  localparam logic [6:0] G_LG    = 7'b1000010;
  localparam logic [6:0] G_LR    = 7'b0101111;
  localparam logic [6:0] G_0     = 7'b1000000;
  localparam logic [6:0] G_5     = 7'b0010010;
  localparam logic [6:0] G_7     = 7'b1111000;
  localparam logic [6:0] G_8     = 7'b0000000;
  localparam logic [6:0] G_9     = 7'b0010000;
  localparam logic [6:0] G_A     = 7'b0001000;
  localparam logic [6:0] G_C     = 7'b1000110;
  localparam logic [6:0] G_E     = 7'b0000110;
  localparam logic [6:0] G_F     = 7'b0001110;

  logic       clk;
  logic       rst_n;
  logic [7:0] channel_in;
  logic [1:0] sel;
  logic [3:0] anodes;
  logic [6:0] segments;
  logic       dp;

  int n_checks;
  int n_fail;

  rgb_channel_display #(
    .REFRESH_DIV (RD),
    .BLANK       (BL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .channel_in (channel_in),
    .sel        (sel),
    .anodes     (anodes),
    .segments   (segments),
    .dp         (dp)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  // Single checking task
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs ncyc cycles of a frame starting at a negedge with the scan at
  // slot 0 of digit 0. Expected glyphs g[3:0] are per digit. Inputs are
  // driven every cycle; the final cycle of a full frame is the snapshot.
  task automatic run_frame(input logic [6:0] g3, input logic [6:0] g2,
                           input logic [6:0] g1, input logic [6:0] g0,
                           input logic [1:0] nsel, input logic [7:0] nval,
                           input bit toggle, input int ncyc);
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    int dig;
    int cnt;
    for (int c = 0; c < ncyc; c++) begin
      sel = nsel;
      if (toggle) channel_in = (c == FRAME - 1) ? 8'h88 : ((c % 2) ? 8'h88 : 8'h00);
      else        channel_in = nval;
      @(posedge clk);
      #1;
      dig = c / RD;
      cnt = c % RD;
      case (dig)
        0: exp_seg = g0;
        1: exp_seg = g1;
        2: exp_seg = g2;
        default: exp_seg = g3;
      endcase
      if (cnt < BL) exp_an = 4'b1111;
      else begin
        case (dig)
          0: exp_an = 4'b1110;
          1: exp_an = 4'b1101;
          2: exp_an = 4'b1011;
          default: exp_an = 4'b0111;
        endcase
      end
      check($sformatf("anodes d%0d c%0d", dig, cnt), {28'd0, anodes}, {28'd0, exp_an});
      check($sformatf("segments d%0d c%0d", dig, cnt), {25'd0, segments}, {25'd0, exp_seg});
      if (c == 0) check("dp", {31'd0, dp}, 32'd1);
      @(negedge clk);
    end
  endtask

  // Stimulus
  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    sel        = 2'b10;
    channel_in = 8'hA5;

    // Reset hold
    repeat (3) @(posedge clk);
    #1;
    check("rst anodes", {28'd0, anodes}, {28'd0, 4'b1111});
    check("rst segments", {25'd0, segments}, {25'd0, 7'b1111111});
    check("rst dp", {31'd0, dp}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 0: reset shadow shows dashes; snapshot red A5
    run_frame(G_DASH, G_DASH, G_DASH, G_DASH, 2'b10, 8'hA5, 1'b0, FRAME);
    // Frame 1: r _ A 5; snapshot blue 0F
    run_frame(G_LR, G_BLANK, G_A, G_5, 2'b00, 8'h0F, 1'b0, FRAME);
    // Frame 2: b _ 0 F; channel toggles, snapshot holds green 88
    run_frame(G_LB, G_BLANK, G_0, G_F, 2'b01, 8'h00, 1'b1, FRAME);
    // Frame 3: G _ 8 8; snapshot "none"
    run_frame(G_LG, G_BLANK, G_8, G_8, 2'b11, 8'h3C, 1'b0, FRAME);
    // Frame 4: dashes; snapshot green C9
    run_frame(G_DASH, G_DASH, G_DASH, G_DASH, 2'b01, 8'hC9, 1'b0, FRAME);
    // Frame 5: G _ C 9; snapshot red 7E
    run_frame(G_LG, G_BLANK, G_C, G_9, 2'b10, 8'h7E, 1'b0, FRAME);
    // Frame 6 partial: r _ 7 E, stop inside digit 2
    run_frame(G_LR, G_BLANK, G_7, G_E, 2'b10, 8'h7E, 1'b0, 2 * RD + 4);

    // Asynchronous reset mid-digit-2 while digit 2 anode is low
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst anodes", {28'd0, anodes}, {28'd0, 4'b1111});
    check("async rst segments", {25'd0, segments}, {25'd0, 7'b1111111});
    check("async rst dp", {31'd0, dp}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Scan restarts at digit 0 with the reset shadow
    run_frame(G_DASH, G_DASH, G_DASH, G_DASH, 2'b00, 8'h5A, 1'b0, FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
